// File: rtl/cmd_executor_pkg.sv
// Shared definitions for the command executor: opcodes, word0 field layout,
// FSM encoding and the per-opcode command size.
package cmd_executor_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_MOVI = 8'h01;
  localparam logic [7:0] OP_ADD  = 8'h02;
  localparam logic [7:0] OP_SUB  = 8'h03;
  localparam logic [7:0] OP_JMP  = 8'h04;
  localparam logic [7:0] OP_JZ   = 8'h05;
  localparam logic [7:0] OP_ADDI = 8'h06;
  localparam logic [7:0] OP_CMPJ = 8'h08;
  localparam logic [7:0] OP_MUL  = 8'h09;
  localparam logic [7:0] OP_HALT = 8'hFF;

  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 8;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 12;
  localparam int RS2_LSB = 16;
  localparam int SEL_W   = 4;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_DONE, S_HALTED} state_t;

  function automatic logic [1:0] cmd_size(input logic [7:0] op);
    case (op)
      OP_MOVI, OP_JMP, OP_JZ, OP_ADDI: return 2'd2;
      OP_CMPJ:                         return 2'd3;
      default:                         return 2'd1;
    endcase
  endfunction

  function automatic logic is_legal(input logic [7:0] op);
    case (op)
      OP_NOP, OP_MOVI, OP_ADD, OP_SUB, OP_JMP, OP_JZ,
      OP_ADDI, OP_CMPJ, OP_MUL, OP_HALT: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cmd_executor_serial_multiplier.sv
// Shift-add multiplier, one partial product per cycle for W cycles after start.
// done is combinational on the last step; product is valid while done is high.
module serial_multiplier #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  acc, mcand, mplier, step_sum;
  logic [CW-1:0] cnt;

  assign step_sum = acc + (mplier[0] ? mcand : '0);
  assign done     = busy && (cnt == CW'(W - 1));
  assign product  = step_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= step_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/cmd_executor.sv
// Executes one latched command window against a local register file and
// reports retirement (size or jump offset) back to the fetcher.
module cmd_executor
  import cmd_executor_pkg::*;
#(
  parameter int WORD_SIZE_ = 32,
  parameter int ADDR_SIZE_ = 32,
  parameter int REG_NUM_   = 16
) (
  input  logic                      CLK_,
  input  logic                      RST_,
  input  logic                      EXEC_FL_,
  input  logic [3*WORD_SIZE_-1:0]   CMD_ARGS_,
  output logic                      READY_FL_,
  output logic [1:0]                PREV_CMD_SIZE_,
  output logic                      JMP_FL_,
  output logic [ADDR_SIZE_-1:0]     NEW_EXEC_ADDR_OFFSET_,
  output logic                      HALT_FL_,
  output logic                      ILLEGAL_FL_,
  input  logic [3:0]                DBG_REG_SEL_,
  output logic [WORD_SIZE_-1:0]     DBG_REG_VAL_
);

  state_t state, state_nxt;

  logic [3*WORD_SIZE_-1:0] cmd;
  logic [WORD_SIZE_-1:0]   regs [REG_NUM_];
  logic [WORD_SIZE_-1:0]   src1, src2, word1, word2;
  logic [WORD_SIZE_-1:0]   wb_val, jump_word, mul_product;
  logic [7:0]              opcode;
  logic [SEL_W-1:0]        rd;
  logic                    wb_en, take, mul_start, mul_busy, mul_done;
  logic                    unused_bits;

  assign opcode       = cmd[OPC_LSB +: OPC_W];
  assign rd           = cmd[RD_LSB +: SEL_W];
  assign word1        = cmd[WORD_SIZE_ +: WORD_SIZE_];
  assign word2        = cmd[2*WORD_SIZE_ +: WORD_SIZE_];
  assign unused_bits  = ^{cmd[WORD_SIZE_-1:RD_LSB+SEL_W], mul_busy};
  assign DBG_REG_VAL_ = regs[DBG_REG_SEL_];

  serial_multiplier #(.W(WORD_SIZE_)) u_mul (
    .clk     (CLK_),
    .rst     (RST_),
    .start   (mul_start),
    .a       (src1),
    .b       (src2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge CLK_ or posedge RST_) begin
    if (RST_) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    case (state)
      S_IDLE: if (EXEC_FL_) state_nxt = S_EXEC;
      S_EXEC: begin
        if (opcode == OP_MUL) begin
          mul_start = 1'b1;
          state_nxt = S_MUL;
        end else if (opcode == OP_HALT) begin
          state_nxt = S_HALTED;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_MUL:    if (mul_done) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle opcodes; undefined opcodes fall through as NOP.
  always_comb begin
    wb_en     = 1'b0;
    wb_val    = '0;
    take      = 1'b0;
    jump_word = word1;
    case (opcode)
      OP_MOVI: begin wb_en = 1'b1; wb_val = word1;        end
      OP_ADD:  begin wb_en = 1'b1; wb_val = src1 + src2;  end
      OP_SUB:  begin wb_en = 1'b1; wb_val = src1 - src2;  end
      OP_ADDI: begin wb_en = 1'b1; wb_val = src1 + word1; end
      OP_JMP:  take = 1'b1;
      OP_JZ:   take = (src1 == '0);
      OP_CMPJ: begin take = (src1 == word1); jump_word = word2; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_ or posedge RST_) begin
    if (RST_) begin
      for (int i = 0; i < REG_NUM_; i++) regs[i] <= '0;
      cmd                   <= '0;
      src1                  <= '0;
      src2                  <= '0;
      READY_FL_             <= 1'b0;
      PREV_CMD_SIZE_        <= '0;
      JMP_FL_               <= 1'b0;
      NEW_EXEC_ADDR_OFFSET_ <= '0;
      HALT_FL_              <= 1'b0;
      ILLEGAL_FL_           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (EXEC_FL_) begin
          cmd  <= CMD_ARGS_;
          src1 <= regs[CMD_ARGS_[RS1_LSB +: SEL_W]];
          src2 <= regs[CMD_ARGS_[RS2_LSB +: SEL_W]];
        end
        S_EXEC: begin
          if (opcode == OP_HALT) begin
            HALT_FL_ <= 1'b1;
          end else if (opcode != OP_MUL) begin
            if (wb_en && rd != '0) regs[rd] <= wb_val;
            PREV_CMD_SIZE_        <= cmd_size(opcode);
            JMP_FL_               <= take;
            NEW_EXEC_ADDR_OFFSET_ <= take ? ADDR_SIZE_'($signed(jump_word)) : '0;
            READY_FL_             <= 1'b1;
            if (!is_legal(opcode)) ILLEGAL_FL_ <= 1'b1;
          end
        end
        S_MUL: if (mul_done) begin
          if (rd != '0) regs[rd] <= mul_product;
          PREV_CMD_SIZE_        <= 2'd1;
          JMP_FL_               <= 1'b0;
          NEW_EXEC_ADDR_OFFSET_ <= '0;
          READY_FL_             <= 1'b1;
        end
        S_DONE:  READY_FL_ <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cmd_executor.md
Name: cmd_executor

Overview:
- Execution stage directly downstream of the Fetcher. Consumes the 3-word command window and EXEC_FL_ from the Fetcher.
- Decodes and executes one command at a time against a local register file.
- Returns one READY_FL_ pulse per command, together with the command size or jump offset, so the Fetcher can advance IP.
- Includes a multi-cycle shift-add multiply and a halt state.

Parameters:
WORD_SIZE_, 32, data word width in bits; the command window is 3 words wide.
ADDR_SIZE_, 32, width of the jump offset; must match the Fetcher.
REG_NUM_, 16, register file depth; register select fields are 4 bits.

Ports:
CLK_  in  1  clock
RST_  in  1  asynchronous, active-high reset
EXEC_FL_  in  1  command window valid (from Fetcher)
CMD_ARGS_  in  3*WORD_SIZE_  word0 = [WORD_SIZE_-1:0], word1 next, word2 top
READY_FL_  out  1  one-cycle pulse: command retired
PREV_CMD_SIZE_  out  2  size in words of the retired command (1..3)
JMP_FL_  out  1  valid with READY_FL_: take the offset instead of the size
NEW_EXEC_ADDR_OFFSET_  out  ADDR_SIZE_  signed relative jump, applied as IP + offset
HALT_FL_  out  1  high after HALT retires
ILLEGAL_FL_  out  1  sticky: an undefined opcode was seen
DBG_REG_SEL_  in  4  debug register select
DBG_REG_VAL_  out  WORD_SIZE_  combinational read of regs[DBG_REG_SEL_]

Behaviour:
- Reset (async, RST_=1):
  - All registers in the register file are cleared to 0 and the state goes to IDLE.
  - READY_FL_, JMP_FL_, HALT_FL_ and ILLEGAL_FL_ are 0; PREV_CMD_SIZE_ and NEW_EXEC_ADDR_OFFSET_ are 0.
  - Reset during MUL abandons the operation; no writeback occurs.
- Word0 fields: [7:0] opcode, [11:8] rd, [15:12] rs1, [19:16] rs2. r0 always reads 0 and writes to it are dropped.
- Opcodes (size in words):
  - 0x00 NOP (1).
  - 0x01 MOVI rd=word1 (2).
  - 0x02 ADD rd=rs1+rs2 (1).
  - 0x03 SUB rd=rs1-rs2 (1).
  - 0x04 JMP offset=word1 (2).
  - 0x05 JZ: jump by word1 if rs1==0 (2).
  - 0x06 ADDI rd=rs1+word1 (2).
  - 0x08 CMPJ: jump by word2 if rs1==word1 (3).
  - 0x09 MUL rd=low WORD_SIZE_ bits of rs1*rs2 (1).
  - 0xFF HALT (1).
- Arithmetic: all arithmetic wraps modulo 2^WORD_SIZE_. The offset is word1 or word2, truncated or sign-extended to ADDR_SIZE_.
- Undefined opcode: executes as NOP with size 1 and sets ILLEGAL_FL_, which stays set until reset.
- States: IDLE, EXEC, MUL, DONE, HALTED.
  - IDLE: EXEC_FL_ is sampled only in this state. If it is 1, latch CMD_ARGS_ and the operands, then go to EXEC.
  - EXEC: perform writeback, register PREV_CMD_SIZE_, JMP_FL_ and the offset, set READY_FL_<=1, go to DONE. MUL instead loads the multiplier and counter and goes to MUL. HALT sets HALT_FL_<=1 and goes to HALTED without raising READY_FL_.
  - MUL: one shift-add step per cycle for WORD_SIZE_ cycles. At count==WORD_SIZE_-1, write back, set READY_FL_<=1, go to DONE.
  - DONE: READY_FL_<=0, go to IDLE. READY_FL_ is therefore high for exactly one cycle.
  - HALTED: absorbing state; only reset leaves it.
- Latency from the edge that samples EXEC_FL_=1 to READY_FL_ high:
  - 2 edges for single-cycle ops.
  - 2+WORD_SIZE_ edges for MUL.
- Handshake: the Fetcher clears EXEC_FL_ on the edge where it sees READY_FL_. By the time the IDLE state is reached, EXEC_FL_=0, so a command is never executed twice.
- CMD_ARGS_ may change after the IDLE latch; only latched copies are used.
- JMP_FL_=0 on non-taken branches; PREV_CMD_SIZE_ is always valid while READY_FL_=1.
- Writeback and the register read of the next command never overlap, so no forwarding is needed.

Decomposition:
- Package cmd_executor_pkg holds:
  - opcode constants
  - field bit positions
  - state encoding
  - command size lookup
- Sub-module serial_multiplier:
  - ports: start, a, b, busy, done, product
  - WORD_SIZE_ iterations
  - async reset

Test Plan:
- MOVI r1,5; MOVI r2,7; ADD r3,r1,r2 -> r3=12; three READY_FL_ pulses with sizes 2,2,1; JMP_FL_=0 throughout.
- r1=0, JZ r1,+4 -> JMP_FL_=1, offset=4; then r1=1, JZ r1,+4 -> JMP_FL_=0, size=2.
- r4=9, CMPJ r4,9,-3 -> JMP_FL_=1, offset=0xFFFFFFFD; with word1=8 -> no jump, size=3.
- r1=0xFFFF, r2=0x10001, MUL r5,r1,r2 -> r5=0xFFFFFFFF; READY_FL_ exactly 34 edges after EXEC_FL_ is sampled; assert reset mid-MUL -> r5 unchanged, READY_FL_ never pulses.
- Opcode 0x7E -> ILLEGAL_FL_=1, size 1; HALT -> HALT_FL_=1, no further READY_FL_ even with EXEC_FL_ held at 1.
- MOVI r0,3 -> r0 reads 0; DBG_REG_VAL_ shows every register correctly after each retire.
